i_decode: RTL and testbench

I_DECODE -- requirements
Module: i_decode

---
 rtl/i_decode.sv | 156 +++++++++++++++
 tb/tb_i_decode.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_decode.sv
// ---------------------------------------------------------------------------
// i_decode
//
// Instruction decode stage. Holds a 16 x 32-bit register file (no hardwired
// zero register), reads the two source operands named by the incoming
// instruction, classifies the opcode and captures everything into a single
// decode register that downstream stages consume. Also counts how many
// microcode instructions have been decoded.
//
// Ports
//   clk                  rising-edge clock for all state
//   rst                  synchronous active-high reset
//   filteredInstruction  instruction from fetch (normal or microcode)
//   programCounter       PC belonging to filteredInstruction
//   ucode_flag           1 = instruction comes from the microcode ROM
//   stall                downstream not ready, hold the decode register
//   flush                taken branch resolved in execute, kill decode
//   wb_en/wb_rd/wb_data  register-file write port from writeback
//   dec_valid            decode register holds a live instruction
//   dec_opcode/rd/rs     instruction fields [31:25], [24:21], [20:17]
//   dec_rd_val/rs_val    register-file contents of rd and rs
//   dec_imm              sign-extended instruction bits [15:0]
//   dec_pc               captured programCounter
//   dec_is_branch        opcode is the branch (B) class
//   dec_is_nop           opcode is the NOP class
//   dec_writes_rd        instruction writes its rd register
//   dec_ucode            captured ucode_flag
//   ucode_count          saturating count of decoded microcode instructions
// ---------------------------------------------------------------------------
module i_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] filteredInstruction,
  input  logic [31:0] programCounter,
  input  logic        ucode_flag,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        dec_valid,
  output logic [6:0]  dec_opcode,
  output logic [3:0]  dec_rd,
  output logic [3:0]  dec_rs,
  output logic [31:0] dec_rd_val,
  output logic [31:0] dec_rs_val,
  output logic [31:0] dec_imm,
  output logic [31:0] dec_pc,
  output logic        dec_is_branch,
  output logic        dec_is_nop,
  output logic        dec_writes_rd,
  output logic        dec_ucode,
  output logic [15:0] ucode_count
);

  logic [31:0] regs [16];

  logic [6:0]  opcode;
  logic [3:0]  rd_idx;
  logic [3:0]  rs_idx;
  logic [31:0] rd_read;
  logic [31:0] rs_read;
  logic [31:0] imm_ext;
  logic        is_branch;
  logic        is_nop;
  logic        writes_rd;
  logic        capture;

  assign opcode  = filteredInstruction[31:25];
  assign rd_idx  = filteredInstruction[24:21];
  assign rs_idx  = filteredInstruction[20:17];
  assign imm_ext = {{16{filteredInstruction[15]}}, filteredInstruction[15:0]};
  assign capture = !flush && !stall;

  // Operand reads are combinational. A writeback landing on the same index
  // in this cycle is forwarded so the decode register never captures a
  // value that is one write stale.
  always_comb begin
    rd_read = regs[rd_idx];
    rs_read = regs[rs_idx];
    if (wb_en && (wb_rd == rd_idx)) rd_read = wb_data;
    if (wb_en && (wb_rd == rs_idx)) rs_read = wb_data;
  end

  // Opcode classification. Opcodes with [6:5]=11 are the control group
  // and never write rd; everything else, including the multiply opcodes
  // that should only arrive from microcode, is treated as a plain writer.
  always_comb begin
    is_branch = (opcode[6:5] == 2'b11) && (opcode[3:0] == 4'b0000);
    is_nop    = (opcode[6:5] == 2'b11) && (opcode[3:0] == 4'b0010);
    writes_rd = (opcode[6:5] != 2'b11);
  end

  // Register file. Writeback is accepted every cycle independent of
  // stall/flush because it belongs to an older instruction already past
  // this stage; only reset overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Decode register. Flush wins over stall and only has to kill validity
  // and the class flags; the remaining fields are ignored by consumers
  // while dec_valid is low, so they are simply left as they were. A stall
  // holds every field, including the operand values, so a later writeback
  // to a source register cannot alter an instruction already decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid     <= 1'b0;
      dec_opcode    <= '0;
      dec_rd        <= '0;
      dec_rs        <= '0;
      dec_rd_val    <= '0;
      dec_rs_val    <= '0;
      dec_imm       <= '0;
      dec_pc        <= '0;
      dec_is_branch <= 1'b0;
      dec_is_nop    <= 1'b0;
      dec_writes_rd <= 1'b0;
      dec_ucode     <= 1'b0;
    end else if (flush) begin
      dec_valid     <= 1'b0;
      dec_is_branch <= 1'b0;
      dec_is_nop    <= 1'b0;
      dec_writes_rd <= 1'b0;
      dec_ucode     <= 1'b0;
    end else if (!stall) begin
      dec_valid     <= 1'b1;
      dec_opcode    <= opcode;
      dec_rd        <= rd_idx;
      dec_rs        <= rs_idx;
      dec_rd_val    <= rd_read;
      dec_rs_val    <= rs_read;
      dec_imm       <= imm_ext;
      dec_pc        <= programCounter;
      dec_is_branch <= is_branch;
      dec_is_nop    <= is_nop;
      dec_writes_rd <= writes_rd;
      dec_ucode     <= ucode_flag;
    end
  end

  // Microcode counter. It only advances on a real capture of a microcode
  // instruction and sticks at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucode_count <= '0;
    end else if (capture && ucode_flag && (ucode_count != 16'hFFFF)) begin
      ucode_count <= ucode_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_i_decode.sv
// ---------------------------------------------------------------------------
// tb_i_decode
//
// Self-checking bench for i_decode. Every stimulus cycle runs a small
// behavioural model of the decode stage, pushes the expected register
// contents onto a scoreboard queue, and after the clock edge pops and
// compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_i_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] filteredInstruction;
  logic [31:0] programCounter;
  logic        ucode_flag;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        dec_valid;
  logic [6:0]  dec_opcode;
  logic [3:0]  dec_rd;
  logic [3:0]  dec_rs;
  logic [31:0] dec_rd_val;
  logic [31:0] dec_rs_val;
  logic [31:0] dec_imm;
  logic [31:0] dec_pc;
  logic        dec_is_branch;
  logic        dec_is_nop;
  logic        dec_writes_rd;
  logic        dec_ucode;
  logic [15:0] ucode_count;

  // Check modes: 0 = every field, 1 = flushed (valid, flags, count),
  // 2 = counter only.
  typedef struct {
    int          mode;
    logic        valid;
    logic [6:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [31:0] rd_val;
    logic [31:0] rs_val;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        br;
    logic        nop;
    logic        wr;
    logic        uc;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbQueue[$];
  exp_t        m;
  logic [31:0] mRegs [16];
  int          checkCount = 0;
  int          passCount  = 0;

  i_decode dut (
    .clk                 (clk),
    .rst                 (rst),
    .filteredInstruction (filteredInstruction),
    .programCounter      (programCounter),
    .ucode_flag          (ucode_flag),
    .stall               (stall),
    .flush               (flush),
    .wb_en               (wb_en),
    .wb_rd               (wb_rd),
    .wb_data             (wb_data),
    .dec_valid           (dec_valid),
    .dec_opcode          (dec_opcode),
    .dec_rd              (dec_rd),
    .dec_rs              (dec_rs),
    .dec_rd_val          (dec_rd_val),
    .dec_rs_val          (dec_rs_val),
    .dec_imm             (dec_imm),
    .dec_pc              (dec_pc),
    .dec_is_branch       (dec_is_branch),
    .dec_is_nop          (dec_is_nop),
    .dec_writes_rd       (dec_writes_rd),
    .dec_ucode           (dec_ucode),
    .ucode_count         (ucode_count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checkCount++;
    if (obs === expv) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
  endtask

  // Pops the oldest expectation and compares it with the DUT outputs.
  task automatic compareNext();
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sbQueue.pop_front();
    checkOutput("ucode_count", {16'h0, ucode_count}, {16'h0, e.cnt});
    if (e.mode <= 1) begin
      checkOutput("dec_valid",     {31'h0, dec_valid},     {31'h0, e.valid});
      checkOutput("dec_is_branch", {31'h0, dec_is_branch}, {31'h0, e.br});
      checkOutput("dec_is_nop",    {31'h0, dec_is_nop},    {31'h0, e.nop});
      checkOutput("dec_writes_rd", {31'h0, dec_writes_rd}, {31'h0, e.wr});
    end
    if (e.mode == 0) begin
      checkOutput("dec_ucode",  {31'h0, dec_ucode},  {31'h0, e.uc});
      checkOutput("dec_opcode", {25'h0, dec_opcode}, {25'h0, e.opcode});
      checkOutput("dec_rd",     {28'h0, dec_rd},     {28'h0, e.rd});
      checkOutput("dec_rs",     {28'h0, dec_rs},     {28'h0, e.rs});
      checkOutput("dec_rd_val", dec_rd_val, e.rd_val);
      checkOutput("dec_rs_val", dec_rs_val, e.rs_val);
      checkOutput("dec_imm",    dec_imm,    e.imm);
      checkOutput("dec_pc",     dec_pc,     e.pc);
    end
  endtask

  // Drives one cycle of inputs, advances the reference model, queues its
  // expectation, then waits for the edge and checks.
  task automatic applyStimulus(input logic r, input logic [31:0] ins,
                               input logic [31:0] pc, input logic uc,
                               input logic st, input logic fl,
                               input logic we, input logic [3:0] wrd,
                               input logic [31:0] wd, input int mode);
    logic [3:0]  ird;
    logic [3:0]  irs;
    logic [6:0]  op;
    rst                 = r;
    filteredInstruction = ins;
    programCounter      = pc;
    ucode_flag          = uc;
    stall               = st;
    flush               = fl;
    wb_en               = we;
    wb_rd               = wrd;
    wb_data             = wd;

    ird = ins[24:21];
    irs = ins[20:17];
    op  = ins[31:25];
    if (r) begin
      m = '{default: 0};
      for (int i = 0; i < 16; i++) mRegs[i] = 32'h0;
    end else begin
      if (fl) begin
        m.valid = 1'b0;
        m.br    = 1'b0;
        m.nop   = 1'b0;
        m.wr    = 1'b0;
        m.uc    = 1'b0;
      end else if (!st) begin
        m.valid  = 1'b1;
        m.opcode = op;
        m.rd     = ird;
        m.rs     = irs;
        m.rd_val = (we && wrd == ird) ? wd : mRegs[ird];
        m.rs_val = (we && wrd == irs) ? wd : mRegs[irs];
        m.imm    = {{16{ins[15]}}, ins[15:0]};
        m.pc     = pc;
        m.br     = (op[6:5] == 2'b11) && (op[3:0] == 4'b0000);
        m.nop    = (op[6:5] == 2'b11) && (op[3:0] == 4'b0010);
        m.wr     = (op[6:5] != 2'b11);
        m.uc     = uc;
        if (uc && m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      end
      if (we) mRegs[wrd] = wd;
    end
    m.mode = (fl && !r && mode == 0) ? 1 : mode;
    sbQueue.push_back(m);

    @(posedge clk);
    #1;
    compareNext();
  endtask

  logic [31:0] instrA;

  initial begin
    // Reset, two cycles.
    applyStimulus(1, 32'h0, 32'h0, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    applyStimulus(1, 32'hFFFF_FFFF, 32'h4, 1, 1, 1, 1, 4'd5, 32'h1234, 0);

    // Fill the register file while decoding random instructions.
    for (int i = 0; i < 16; i++)
      applyStimulus(0, $urandom, 32'h100 + 4 * i, 0, 0, 0, 1, i[3:0],
                    32'h1000_0000 + 32'h11 * i, 0);

    // Basic decode of a multiply opcode arriving without microcode.
    applyStimulus(0, 32'h2086_FFFE, 32'd8, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("basic_valid",  {31'h0, dec_valid},     32'd1);
    checkOutput("basic_opcode", {25'h0, dec_opcode},    32'b0010000);
    checkOutput("basic_rd",     {28'h0, dec_rd},        32'd4);
    checkOutput("basic_rs",     {28'h0, dec_rs},        32'd3);
    checkOutput("basic_imm",    dec_imm,                32'hFFFF_FFFE);
    checkOutput("basic_pc",     dec_pc,                 32'd8);
    checkOutput("basic_wr",     {31'h0, dec_writes_rd}, 32'd1);

    // Same-cycle writeback bypass onto rs=3.
    applyStimulus(0, 32'h2086_FFFE, 32'd12, 0, 0, 0, 1, 4'd3, 32'hDEAD_BEEF, 0);
    checkOutput("bypass_rs_val", dec_rs_val, 32'hDEAD_BEEF);

    // Stall hold: capture A, then three stalled cycles with new inputs and
    // a writeback to A's rs, then release with a fresh instruction.
    instrA = 32'h0A4C_1234;
    applyStimulus(0, instrA, 32'h200, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, $urandom, 32'h300 + i, 1, 1, 0, 1, instrA[20:17],
                    32'hCAFE_0000 + i, 0);
    checkOutput("stall_pc", dec_pc, 32'h200);
    applyStimulus(0, 32'h1E26_8001, 32'h204, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("release_pc", dec_pc, 32'h204);

    // Flush over stall, with a microcode instruction offered.
    applyStimulus(0, 32'h1111_1111, 32'h400, 1, 0, 0, 0, 4'd0, 32'h0, 0);
    applyStimulus(0, 32'h2222_2222, 32'h404, 1, 1, 1, 0, 4'd0, 32'h0, 0);
    checkOutput("flush_valid", {31'h0, dec_valid}, 32'd0);

    // Opcode classes.
    applyStimulus(0, {7'b1100000, 25'h0123456}, 32'h500, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("class_branch", {31'h0, dec_is_branch}, 32'd1);
    applyStimulus(0, {7'b1100010, 25'h0abcdef}, 32'h504, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("class_nop", {31'h0, dec_is_nop}, 32'd1);
    applyStimulus(0, {7'b1100100, 25'h1555555}, 32'h508, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    applyStimulus(0, {7'b1110000, 25'h0000000}, 32'h50C, 0, 0, 0, 0, 4'd0, 32'h0, 0);

    // Counter: reset, five microcode captures, then run into saturation.
    applyStimulus(1, 32'h0, 32'h0, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(0, $urandom, 32'h600 + 4 * i, 1, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("count_five", {16'h0, ucode_count}, 32'd5);
    for (int i = 0; i < 65535; i++)
      applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0, 4'd0, 32'h0, 2);
    checkOutput("count_sat", {16'h0, ucode_count}, 32'h0000_FFFF);
    applyStimulus(0, $urandom, 32'h700, 1, 0, 0, 1, 4'd7, 32'h7777_7777, 0);

    // Reset mid-stream, then read back a register the reset must clear.
    applyStimulus(1, $urandom, 32'h800, 1, 0, 0, 1, 4'd2, 32'h5555_5555, 0);
    checkOutput("rst_count", {16'h0, ucode_count}, 32'd0);
    checkOutput("rst_valid", {31'h0, dec_valid}, 32'd0);
    applyStimulus(0, 32'h00EE_0000, 32'h804, 0, 0, 0, 0, 4'd0, 32'h0, 0);
    checkOutput("rst_reg_clear", dec_rd_val, 32'd0);

    // Random mix of everything.
    for (int i = 0; i < 60; i++)
      applyStimulus(($urandom_range(0, 19) == 0), $urandom, $urandom,
                    $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                    4'($urandom_range(0, 15)), $urandom, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
